// File: rtl/router_pkt_gen.sv
// Packet generator for the router: header, incrementing payload and XOR parity byte,
// with a stall input and registered outputs.
module router_pkt_gen #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       dest_addr,
   input  logic [5:0]       payload_len,
   input  logic [7:0]       seed,
   input  logic             busy,
   output logic [7:0]       data_out,
   output logic             pkt_valid,
   output logic             gen_busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] pkt_count
);

   typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, PARITY} state_t;

   state_t           state, state_nxt;
   logic [7:0]       seed_q, seed_nxt;
   logic [7:0]       par_q, par_nxt;
   logic [5:0]       remain_q, remain_nxt;
   logic [7:0]       data_nxt;
   logic             pkt_valid_nxt, gen_busy_nxt, done_nxt, err_nxt;
   logic [CNT_W-1:0] count_nxt;

   // State and registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         seed_q    <= 8'd0;
         par_q     <= 8'd0;
         remain_q  <= 6'd0;
         data_out  <= 8'd0;
         pkt_valid <= 1'b0;
         gen_busy  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         pkt_count <= '0;
      end else begin
         state     <= state_nxt;
         seed_q    <= seed_nxt;
         par_q     <= par_nxt;
         remain_q  <= remain_nxt;
         data_out  <= data_nxt;
         pkt_valid <= pkt_valid_nxt;
         gen_busy  <= gen_busy_nxt;
         done      <= done_nxt;
         err       <= err_nxt;
         pkt_count <= count_nxt;
      end
   end

   // Next state and next output values; a stalled edge keeps everything as is
   always_comb begin
      state_nxt     = state;
      seed_nxt      = seed_q;
      par_nxt       = par_q;
      remain_nxt    = remain_q;
      data_nxt      = data_out;
      pkt_valid_nxt = pkt_valid;
      done_nxt      = 1'b0;
      err_nxt       = 1'b0;
      count_nxt     = pkt_count;

      case (state)
         IDLE: begin
            if (start) begin
               if (dest_addr != 2'd3 && payload_len != 6'd0) begin
                  state_nxt     = HEADER;
                  seed_nxt      = seed;
                  remain_nxt    = payload_len;
                  par_nxt       = 8'd0;
                  data_nxt      = {payload_len, dest_addr};
                  pkt_valid_nxt = 1'b1;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         HEADER: begin
            if (!busy) begin
               state_nxt = PAYLOAD;
               par_nxt   = par_q ^ data_out;
               data_nxt  = seed_q;
            end
         end
         PAYLOAD: begin
            if (!busy) begin
               par_nxt = par_q ^ data_out;
               if (remain_q == 6'd1) begin
                  // Parity byte folds in the payload byte being accepted now
                  state_nxt     = PARITY;
                  data_nxt      = par_q ^ data_out;
                  pkt_valid_nxt = 1'b0;
                  remain_nxt    = 6'd0;
               end else begin
                  data_nxt   = data_out + 8'd1;
                  remain_nxt = remain_q - 6'd1;
               end
            end
         end
         PARITY: begin
            if (!busy) begin
               state_nxt = IDLE;
               data_nxt  = 8'd0;
               done_nxt  = 1'b1;
               count_nxt = pkt_count + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      gen_busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_router_pkt_gen.sv
// Self-checking bench for router_pkt_gen: directed scenarios plus randomized traffic
// compared cycle by cycle with a packet-level byte-list model.
module tb_router_pkt_gen;

   localparam int unsigned CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             start;
   logic [1:0]       dest_addr;
   logic [5:0]       payload_len;
   logic [7:0]       seed;
   logic             busy;
   logic [7:0]       data_out;
   logic             pkt_valid;
   logic             gen_busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] pkt_count;

   router_pkt_gen #(.CNT_W(CNT_W)) dut (
      .clock(clock), .reset(reset), .start(start), .dest_addr(dest_addr),
      .payload_len(payload_len), .seed(seed), .busy(busy), .data_out(data_out),
      .pkt_valid(pkt_valid), .gen_busy(gen_busy), .done(done), .err(err),
      .pkt_count(pkt_count)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Model: the packet is a list of bytes; each unstalled edge advances one byte
   logic [7:0] m_bytes[$];
   int         m_idx;
   bit         m_active;
   int         m_count;
   bit         m_done;
   bit         m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_bytes.delete();
      m_idx    = 0;
      m_active = 0;
      m_count  = 0;
      m_done   = 0;
      m_err    = 0;
   endtask

   task automatic model_edge(input logic st, input logic [1:0] da, input logic [5:0] pl,
                             input logic [7:0] sd, input logic bz);
      logic [7:0] par;
      m_done = 0;
      m_err  = 0;
      if (!m_active) begin
         if (st) begin
            if (da == 2'd3 || pl == 6'd0) begin
               m_err = 1;
            end else begin
               m_bytes.delete();
               m_bytes.push_back(8'(pl) * 8'd4 + 8'(da));
               for (int i = 0; i < int'(pl); i++) m_bytes.push_back(8'(int'(sd) + i));
               par = 8'd0;
               foreach (m_bytes[k]) par = par ^ m_bytes[k];
               m_bytes.push_back(par);
               m_idx    = 0;
               m_active = 1;
            end
         end
      end else if (!bz) begin
         m_idx++;
         if (m_idx == m_bytes.size()) begin
            m_active = 0;
            m_done   = 1;
            m_count  = (m_count + 1) % (1 << CNT_W);
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [7:0] exp_data;
      logic       exp_valid;
      exp_data  = m_active ? m_bytes[m_idx] : 8'd0;
      exp_valid = m_active && (m_idx < m_bytes.size() - 1);
      chk({tag, ".data"},  32'(data_out),  32'(exp_data));
      chk({tag, ".valid"}, 32'(pkt_valid), 32'(exp_valid));
      chk({tag, ".gbusy"}, 32'(gen_busy),  32'(m_active));
      chk({tag, ".done"},  32'(done),      32'(m_done));
      chk({tag, ".err"},   32'(err),       32'(m_err));
      chk({tag, ".count"}, 32'(pkt_count), 32'(m_count));
   endtask

   // Called at a falling edge: apply inputs, clock once, check at the next falling edge
   task automatic step(input string tag, input logic st, input logic [1:0] da,
                       input logic [5:0] pl, input logic [7:0] sd, input logic bz);
      start = st; dest_addr = da; payload_len = pl; seed = sd; busy = bz;
      model_edge(st, da, pl, sd, bz);
      @(posedge clock);
      @(negedge clock);
      check_outputs(tag);
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 2'd0, 6'd0, 8'd0, 1'b0);
   endtask

   int cyc;

   initial begin
      reset = 1'b1; start = 1'b0; dest_addr = 2'd0; payload_len = 6'd0; seed = 8'd0; busy = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      check_outputs("reset");
      reset = 1'b0;
      idle("post_reset", 2);

      // Basic packet
      step("basic", 1'b1, 2'd1, 6'd3, 8'hA0, 1'b0);
      chk("basic.hdr", 32'(data_out), 32'h0D);
      step("basic", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      step("basic", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      step("basic", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      step("basic", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      chk("basic.par", 32'(data_out), 32'hAE);
      chk("basic.par_valid", 32'(pkt_valid), 32'h0);
      step("basic", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      chk("basic.done", 32'(done), 32'h1);
      chk("basic.count", 32'(pkt_count), 32'h1);
      idle("basic_tail", 1);

      // Stall on the header
      step("stall", 1'b1, 2'd2, 6'd1, 8'h10, 1'b0);
      step("stall", 1'b0, 2'd0, 6'd0, 8'h00, 1'b1);
      step("stall", 1'b0, 2'd0, 6'd0, 8'h00, 1'b1);
      chk("stall.hold", 32'(data_out), 32'h06);
      step("stall", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      chk("stall.pay", 32'(data_out), 32'h10);
      step("stall", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      chk("stall.par", 32'(data_out), 32'h16);
      step("stall", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      idle("stall_tail", 2);

      // Rejected starts
      step("rej_dest", 1'b1, 2'd3, 6'd5, 8'h33, 1'b0);
      chk("rej_dest.err", 32'(err), 32'h1);
      step("rej_gap", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      step("rej_len", 1'b1, 2'd0, 6'd0, 8'h44, 1'b0);
      chk("rej_len.err", 32'(err), 32'h1);
      chk("rej_len.count", 32'(pkt_count), 32'h2);
      idle("rej_tail", 2);

      // Start pulsed mid-payload is ignored
      step("sbusy", 1'b1, 2'd1, 6'd4, 8'h55, 1'b0);
      step("sbusy", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      step("sbusy", 1'b1, 2'd2, 6'd9, 8'h77, 1'b0);
      for (int i = 0; i < 6; i++) step("sbusy", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      chk("sbusy.count", 32'(pkt_count), 32'h3);

      // Maximum length with payload wrap
      step("max", 1'b1, 2'd0, 6'd63, 8'hF0, 1'b0);
      chk("max.hdr", 32'(data_out), 32'hFC);
      cyc = 1;
      while (gen_busy && cyc < 100) begin
         step("max", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
         if (gen_busy) cyc++;
      end
      chk("max.cycles", 32'(cyc), 32'd65);
      idle("max_tail", 1);

      // Asynchronous reset during payload byte 2
      step("rst", 1'b1, 2'd2, 6'd5, 8'h20, 1'b0);
      step("rst", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      step("rst", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      step("rst", 1'b0, 2'd0, 6'd0, 8'h00, 1'b0);
      chk("rst.pay2", 32'(data_out), 32'h22);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_outputs("rst.async");
      @(negedge clock);
      reset = 1'b0;
      idle("rst_after", 2);
      step("rst_new", 1'b1, 2'd1, 6'd2, 8'h90, 1'b0);
      chk("rst_new.hdr", 32'(data_out), 32'h09);

      // Randomized traffic: random stalls, starts, invalid arguments; count wraps
      for (int i = 0; i < 3000; i++) begin
         logic       st, bz;
         logic [1:0] da;
         logic [5:0] pl;
         st = ($urandom_range(0, 3) == 0);
         bz = ($urandom_range(0, 3) == 0);
         da = 2'($urandom_range(0, 3));
         pl = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
         step("rand", st, da, pl, 8'($urandom), bz);
      end
      idle("drain", 80);
      chk("drain.idle", 32'(gen_busy), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/router_pkt_gen.md
ROUTER_PKT_GEN -- requirements
Module: router_pkt_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, the width of the accepted-packet counter.
REQ-002 Port clock  input  1  single clock; all state updates occur on the rising edge.
REQ-003 Port reset  input  1  reset; asynchronous, active-high.
REQ-004 Port start  input  1  single-cycle request to send one packet; sampled only in IDLE.
REQ-005 Port dest_addr  input  2  destination FIFO select; 0..2 valid, 3 invalid.
REQ-006 Port payload_len  input  6  payload byte count; 1..63 valid, 0 invalid.
REQ-007 Port seed  input  8  value of the first payload byte.
REQ-008 Port busy  input  1  router stall; a byte on data_out is accepted only at a rising edge where busy=0.
REQ-009 Port data_out  output  8  byte driven to the router data input.
REQ-010 Port pkt_valid  output  1  high while header or payload bytes are driven; low for the parity byte.
REQ-011 Port gen_busy  output  1  high whenever the state is not IDLE.
REQ-012 Port done  output  1  one-cycle pulse after the parity byte is accepted.
REQ-013 Port err  output  1  one-cycle pulse when a start request is rejected.
REQ-014 Port pkt_count  output  CNT_W  count of completed packets.

Function
REQ-015 The block SHALL implement states IDLE, HEADER, PAYLOAD and PARITY, with every output registered.
REQ-016 In IDLE, start=1 with a valid dest_addr and payload_len SHALL latch all arguments and move to HEADER at that edge.
REQ-017 In IDLE, start=1 with dest_addr=3 or payload_len=0 SHALL pulse err for one cycle and stay in IDLE, with pkt_valid kept at 0.
REQ-018 While gen_busy=1, start SHALL be ignored.
REQ-019 HEADER SHALL drive data_out={payload_len,dest_addr} with pkt_valid=1.
REQ-020 Payload byte i (0-based) SHALL be (seed+i) mod 256.
REQ-021 PAYLOAD SHALL drive payload bytes with pkt_valid=1 and track the remaining count with a 6-bit down-counter.
REQ-022 PARITY SHALL drive the XOR of the header and all payload bytes, with pkt_valid=0.
REQ-023 At each edge with busy=0, the current byte SHALL be accepted and the next byte SHALL appear on data_out: header to payload 0, payload i to i+1, last payload to parity.
REQ-024 At each edge with busy=1, data_out, pkt_valid, state and the counter SHALL hold unchanged.
REQ-025 When the parity byte is accepted, the block SHALL return to IDLE, drive data_out=0, pulse done and increment pkt_count.
REQ-026 pkt_count SHALL wrap from 2^CNT_W-1 to 0.
REQ-027 With busy=0 throughout, a packet SHALL occupy exactly payload_len+2 cycles from the first header cycle to the end of the parity cycle; done SHALL be high in the following cycle.
REQ-028 The parity accumulator SHALL clear on each accepted start and update only on accepted bytes.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, data_out=0, pkt_valid=0, gen_busy=0, done=0, err=0 and pkt_count=0, regardless of clock.
REQ-030 A reset during a packet SHALL abort the packet with no done pulse; the first start after reset deasserts SHALL be handled as in REQ-016/017.

Verification
REQ-031 Basic packet: dest_addr=1, payload_len=3, seed=8'hA0, busy=0 -> data_out sequence 0D(pkt_valid=1), A0, A1, A2, then AE(pkt_valid=0); done pulses next cycle; pkt_count=1.
REQ-032 Stall: dest_addr=2, payload_len=1, seed=8'h10, busy=1 for the first 2 header cycles -> 06 is held for 3 cycles, then 10, then 16 with pkt_valid=0; done pulses once.
REQ-033 Rejects: start with dest_addr=3, and start with payload_len=0 -> err pulses one cycle each; pkt_valid=0; gen_busy=0; pkt_count is unchanged.
REQ-034 Wrap and maximum length: dest_addr=0, payload_len=63, seed=8'hF0 -> header FC; payload F0..FF then 00..2E; parity matches the bench XOR model; the packet takes 65 cycles.
REQ-035 Reset mid-payload: reset asserted during payload byte 2 -> all outputs are 0 in the same cycle; a new valid start after release produces a correct header.
REQ-036 Start while busy: start pulsed during PAYLOAD -> ignored, with exactly one packet and one done produced.
